// File: rtl/rv32_decoder.sv
// RV32I decode stage: splits a fetched instruction into register addresses, immediate,
// one-hot ALU/opcode classes and exception flags, registered alongside the PC.
module rv32_decoder #(
  parameter int DWIDTH   = 32,
  parameter int IWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int PC_WIDTH = 32
) (
  input  logic                d_clk,
  input  logic                d_rst,
  input  logic [IWIDTH-1:0]   d_i_instr,
  input  logic [PC_WIDTH-1:0] d_i_pc,
  input  logic                d_i_ce,
  input  logic                d_i_stall,
  input  logic                d_i_flush,
  output logic [PC_WIDTH-1:0] d_o_pc,
  output logic [AWIDTH-1:0]   d_o_addr_rs1,
  output logic [AWIDTH-1:0]   d_o_addr_rs2,
  output logic [AWIDTH-1:0]   d_o_addr_rd,
  output logic [AWIDTH-1:0]   d_o_addr_rs1_p,
  output logic [AWIDTH-1:0]   d_o_addr_rs2_p,
  output logic [AWIDTH-1:0]   d_o_addr_rd_p,
  output logic [DWIDTH-1:0]   d_o_imm,
  output logic [2:0]          d_o_funct3,
  output logic [13:0]         d_o_alu,
  output logic [10:0]         d_o_opcode,
  output logic [3:0]          d_o_exception,
  output logic                d_o_ce,
  output logic                d_o_stall,
  output logic                d_o_flush
);

  localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 2, ALU_SLTU = 3, ALU_XOR = 4;
  localparam int ALU_OR = 5, ALU_AND = 6, ALU_SLL = 7, ALU_SRL = 8, ALU_SRA = 9;
  localparam int ALU_EQ = 10, ALU_NEQ = 11, ALU_GE = 12, ALU_GEU = 13;

  localparam int OP_RTYPE = 0, OP_ITYPE = 1, OP_LOAD = 2, OP_STORE = 3, OP_BRANCH = 4;
  localparam int OP_JAL = 5, OP_JALR = 6, OP_LUI = 7, OP_AUIPC = 8, OP_SYSTEM = 9, OP_FENCE = 10;

  localparam int EXC_ILLEGAL = 0, EXC_ECALL = 1, EXC_EBREAK = 2, EXC_MRET = 3;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Register/immediate ALU mapping; alt selects SUB/SRA.
  function automatic logic [13:0] alu_arith(input logic [2:0] f3, input logic alt);
    logic [13:0] r;
    r = 14'b0;
    case (f3)
      3'b000:  if (alt) r[ALU_SUB] = 1'b1; else r[ALU_ADD] = 1'b1;
      3'b001:  r[ALU_SLL] = 1'b1;
      3'b010:  r[ALU_SLT] = 1'b1;
      3'b011:  r[ALU_SLTU] = 1'b1;
      3'b100:  r[ALU_XOR] = 1'b1;
      3'b101:  if (alt) r[ALU_SRA] = 1'b1; else r[ALU_SRL] = 1'b1;
      3'b110:  r[ALU_OR] = 1'b1;
      3'b111:  r[ALU_AND] = 1'b1;
      default: r = 14'b0;
    endcase
    return r;
  endfunction

  function automatic logic [13:0] alu_branch(input logic [2:0] f3);
    logic [13:0] r;
    r = 14'b0;
    case (f3)
      3'b000:  r[ALU_EQ] = 1'b1;
      3'b001:  r[ALU_NEQ] = 1'b1;
      3'b100:  r[ALU_SLT] = 1'b1;
      3'b101:  r[ALU_GE] = 1'b1;
      3'b110:  r[ALU_SLTU] = 1'b1;
      3'b111:  r[ALU_GEU] = 1'b1;
      default: r = 14'b0;
    endcase
    return r;
  endfunction

  logic [6:0]        op_s;
  logic [2:0]        funct3_s;
  logic [6:0]        funct7_s;
  logic [DWIDTH-1:0] imm_i_s, imm_st_s, imm_b_s, imm_j_s, imm_u_s;

  assign op_s     = d_i_instr[6:0];
  assign funct3_s = d_i_instr[14:12];
  assign funct7_s = d_i_instr[31:25];
  assign imm_i_s  = {{(DWIDTH-12){d_i_instr[31]}}, d_i_instr[31:20]};
  assign imm_st_s = {{(DWIDTH-12){d_i_instr[31]}}, d_i_instr[31:25], d_i_instr[11:7]};
  assign imm_b_s  = {{(DWIDTH-12){d_i_instr[31]}}, d_i_instr[7], d_i_instr[30:25],
                     d_i_instr[11:8], 1'b0};
  assign imm_j_s  = {{(DWIDTH-20){d_i_instr[31]}}, d_i_instr[19:12], d_i_instr[20],
                     d_i_instr[30:21], 1'b0};
  assign imm_u_s  = {{(DWIDTH-31){d_i_instr[31]}}, d_i_instr[30:12], 12'h000};

  assign d_o_addr_rs1_p = d_i_instr[19:15];
  assign d_o_addr_rs2_p = d_i_instr[24:20];
  assign d_o_addr_rd_p  = d_i_instr[11:7];
  assign d_o_stall      = d_i_stall;
  assign d_o_flush      = d_i_flush;

  logic [10:0]       dec_opcode_s;
  logic [13:0]       alu_raw_s;
  logic [13:0]       dec_alu_s;
  logic [2:0]        sys_exc_s;
  logic [3:0]        dec_exc_s;
  logic [DWIDTH-1:0] dec_imm_s;
  logic              illegal_s;

  // Opcode classification, immediate selection and legality checks.
  always_comb begin
    dec_opcode_s = 11'b0;
    alu_raw_s    = 14'b0;
    sys_exc_s    = 3'b0;
    dec_imm_s    = imm_i_s;
    illegal_s    = 1'b0;
    case (op_s)
      OPC_RTYPE: begin
        dec_opcode_s[OP_RTYPE] = 1'b1;
        if ((funct7_s == 7'b0000000) ||
            ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)))) begin
          alu_raw_s = alu_arith(funct3_s, d_i_instr[30]);
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_ITYPE: begin
        dec_opcode_s[OP_ITYPE] = 1'b1;
        // Only shifts constrain funct7; ADDI never becomes SUB.
        if (((funct3_s == 3'b001) && (funct7_s != 7'b0000000)) ||
            ((funct3_s == 3'b101) && (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000))) begin
          illegal_s = 1'b1;
        end else begin
          alu_raw_s = alu_arith(funct3_s, (funct3_s == 3'b101) & d_i_instr[30]);
        end
      end
      OPC_LOAD: begin
        dec_opcode_s[OP_LOAD] = 1'b1;
        alu_raw_s[ALU_ADD]    = 1'b1;
      end
      OPC_STORE: begin
        dec_opcode_s[OP_STORE] = 1'b1;
        alu_raw_s[ALU_ADD]     = 1'b1;
        dec_imm_s              = imm_st_s;
      end
      OPC_BRANCH: begin
        dec_opcode_s[OP_BRANCH] = 1'b1;
        dec_imm_s               = imm_b_s;
        if (funct3_s[2:1] == 2'b01) begin
          illegal_s = 1'b1;
        end else begin
          alu_raw_s = alu_branch(funct3_s);
        end
      end
      OPC_JAL: begin
        dec_opcode_s[OP_JAL] = 1'b1;
        alu_raw_s[ALU_ADD]   = 1'b1;
        dec_imm_s            = imm_j_s;
      end
      OPC_JALR: begin
        dec_opcode_s[OP_JALR] = 1'b1;
        if (funct3_s != 3'b000) begin
          illegal_s = 1'b1;
        end else begin
          alu_raw_s[ALU_ADD] = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_opcode_s[OP_LUI] = 1'b1;
        alu_raw_s[ALU_ADD]   = 1'b1;
        dec_imm_s            = imm_u_s;
      end
      OPC_AUIPC: begin
        dec_opcode_s[OP_AUIPC] = 1'b1;
        alu_raw_s[ALU_ADD]     = 1'b1;
        dec_imm_s              = imm_u_s;
      end
      OPC_SYSTEM: begin
        dec_opcode_s[OP_SYSTEM] = 1'b1;
        if (funct3_s == 3'b000) begin
          case (d_i_instr[31:20])
            12'h000: sys_exc_s[EXC_ECALL-1]  = 1'b1;
            12'h001: sys_exc_s[EXC_EBREAK-1] = 1'b1;
            12'h302: sys_exc_s[EXC_MRET-1]   = 1'b1;
            default: illegal_s = 1'b1;
          endcase
        end else begin
          sys_exc_s = 3'b0;
        end
      end
      OPC_FENCE: begin
        dec_opcode_s[OP_FENCE] = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Illegal instructions never drive the ALU and carry only the ILLEGAL flag.
  always_comb begin
    if (illegal_s) begin
      dec_alu_s = 14'b0;
      dec_exc_s = 4'b0001;
    end else begin
      dec_alu_s = alu_raw_s;
      dec_exc_s = {sys_exc_s, 1'b0};
    end
  end

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DWIDTH-1:0]   imm_q, imm_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [13:0]         alu_q, alu_d;
  logic [10:0]         opcode_q, opcode_d;
  logic [3:0]          exc_q, exc_d;
  logic                ce_q, ce_d;
  logic                load_s;

  assign load_s = d_i_ce & ~d_i_stall & ~d_i_flush;

  // Next-state: load on accepted input, otherwise hold; flush only kills the valid.
  always_comb begin
    pc_d     = pc_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    funct3_d = funct3_q;
    alu_d    = alu_q;
    opcode_d = opcode_q;
    exc_d    = exc_q;
    if (load_s) begin
      pc_d     = d_i_pc;
      rs1_d    = d_i_instr[19:15];
      rs2_d    = d_i_instr[24:20];
      rd_d     = d_i_instr[11:7];
      imm_d    = dec_imm_s;
      funct3_d = funct3_s;
      alu_d    = dec_alu_s;
      opcode_d = dec_opcode_s;
      exc_d    = dec_exc_s;
    end else begin
      pc_d = pc_q;
    end
    if (d_i_flush) begin
      ce_d = 1'b0;
    end else if (d_i_stall) begin
      ce_d = ce_q;
    end else begin
      ce_d = d_i_ce;
    end
  end

  // Pipeline registers toward execute.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      pc_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      funct3_q <= 3'b0;
      alu_q    <= 14'b0;
      opcode_q <= 11'b0;
      exc_q    <= 4'b0;
      ce_q     <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      funct3_q <= funct3_d;
      alu_q    <= alu_d;
      opcode_q <= opcode_d;
      exc_q    <= exc_d;
      ce_q     <= ce_d;
    end
  end

  assign d_o_pc        = pc_q;
  assign d_o_addr_rs1  = rs1_q;
  assign d_o_addr_rs2  = rs2_q;
  assign d_o_addr_rd   = rd_q;
  assign d_o_imm       = imm_q;
  assign d_o_funct3    = funct3_q;
  assign d_o_alu       = alu_q;
  assign d_o_opcode    = opcode_q;
  assign d_o_exception = exc_q;
  assign d_o_ce        = ce_q;

endmodule

// File: tb/tb_rv32_decoder.sv
// Scoreboard bench for rv32_decoder: directed RV32I encodings plus randomized
// instructions and pipeline control, checked against an arithmetic decode model.
module tb_rv32_decoder;

  logic        d_clk = 1'b0;
  logic        d_rst = 1'b0;
  logic [31:0] d_i_instr = 32'h0;
  logic [31:0] d_i_pc = 32'h0;
  logic        d_i_ce = 1'b0, d_i_stall = 1'b0, d_i_flush = 1'b0;
  logic [31:0] d_o_pc, d_o_imm;
  logic [4:0]  d_o_addr_rs1, d_o_addr_rs2, d_o_addr_rd;
  logic [4:0]  d_o_addr_rs1_p, d_o_addr_rs2_p, d_o_addr_rd_p;
  logic [2:0]  d_o_funct3;
  logic [13:0] d_o_alu;
  logic [10:0] d_o_opcode;
  logic [3:0]  d_o_exception;
  logic        d_o_ce, d_o_stall, d_o_flush;

  rv32_decoder dut (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_instr(d_i_instr), .d_i_pc(d_i_pc),
    .d_i_ce(d_i_ce), .d_i_stall(d_i_stall), .d_i_flush(d_i_flush),
    .d_o_pc(d_o_pc), .d_o_addr_rs1(d_o_addr_rs1), .d_o_addr_rs2(d_o_addr_rs2),
    .d_o_addr_rd(d_o_addr_rd), .d_o_addr_rs1_p(d_o_addr_rs1_p),
    .d_o_addr_rs2_p(d_o_addr_rs2_p), .d_o_addr_rd_p(d_o_addr_rd_p),
    .d_o_imm(d_o_imm), .d_o_funct3(d_o_funct3), .d_o_alu(d_o_alu),
    .d_o_opcode(d_o_opcode), .d_o_exception(d_o_exception), .d_o_ce(d_o_ce),
    .d_o_stall(d_o_stall), .d_o_flush(d_o_flush)
  );

  always #5 d_clk = ~d_clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    bit          imm_chk;
    logic [2:0]  f3;
    logic [13:0] alu;
    logic [10:0] opc;
    logic [3:0]  exc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // funct3 -> ALU bit index for register/immediate ops, and for branches (-1 = illegal)
  localparam int RMAP [0:7] = '{0, 7, 2, 3, 4, 8, 5, 6};
  localparam int BMAP [0:7] = '{10, 11, -1, -1, 2, 12, 3, 13};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.pc = 32'h0; e.rs1 = 5'h0; e.rs2 = 5'h0; e.rd = 5'h0; e.imm = 32'h0;
    e.imm_chk = 1'b1; e.f3 = 3'h0; e.alu = 14'h0; e.opc = 11'h0; e.exc = 4'h0;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int cls, alu, exc, imm, f3, f7, sgn;
    bit ill;
    cls = -1; alu = -1; exc = -1; ill = 1'b0;
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    sgn = ins[31] ? 1 : 0;
    imm = int'(ins[31:20]) - sgn * 4096;
    case (int'(ins[6:0]))
      'h33: begin
        cls = 0;
        if (f7 == 0) alu = RMAP[f3];
        else if (f7 == 32 && f3 == 0) alu = 1;
        else if (f7 == 32 && f3 == 5) alu = 9;
        else ill = 1'b1;
      end
      'h13: begin
        cls = 1;
        if ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32)) ill = 1'b1;
        else if (f3 == 5 && f7 == 32) alu = 9;
        else alu = RMAP[f3];
      end
      'h03: begin cls = 2; alu = 0; end
      'h23: begin cls = 3; alu = 0; imm = f7 * 32 + int'(ins[11:7]) - sgn * 4096; end
      'h63: begin
        cls = 4;
        imm = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - sgn * 4096;
        if (BMAP[f3] < 0) ill = 1'b1; else alu = BMAP[f3];
      end
      'h6F: begin
        cls = 5; alu = 0;
        imm = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
              - sgn * (1 << 20);
      end
      'h67: begin cls = 6; if (f3 != 0) ill = 1'b1; else alu = 0; end
      'h37: begin cls = 7; alu = 0; imm = int'(ins & 32'hFFFF_F000); end
      'h17: begin cls = 8; alu = 0; imm = int'(ins & 32'hFFFF_F000); end
      'h73: begin
        cls = 9;
        if (f3 == 0) begin
          case (int'(ins[31:20]))
            0:       exc = 1;
            1:       exc = 2;
            'h302:   exc = 3;
            default: ill = 1'b1;
          endcase
        end
      end
      'h0F: cls = 10;
      default: ill = 1'b1;
    endcase
    if (ill) begin alu = -1; exc = 0; end
    e.pc      = pc;
    e.rs1     = ins[19:15];
    e.rs2     = ins[24:20];
    e.rd      = ins[11:7];
    e.f3      = ins[14:12];
    e.imm     = imm;
    e.imm_chk = (cls >= 0);
    e.alu     = (alu >= 0) ? (14'd1 << alu) : 14'd0;
    e.opc     = (cls >= 0) ? (11'd1 << cls) : 11'd0;
    e.exc     = (exc >= 0) ? (4'd1 << exc) : 4'd0;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] ops [0:10];
    logic [31:0] ins;
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
    ins = $urandom;
    k   = $urandom_range(0, 12);
    if (k <= 10) ins[6:0] = ops[k];
    else if (k == 11) ins[6:0] = 7'($urandom_range(0, 127));
    else ins[6:0] = 7'h7F;
    if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
      ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if (ins[6:0] == 7'h73 && $urandom_range(0, 1) == 1) begin
      k = $urandom_range(0, 3);
      ins[31:20] = (k == 0) ? 12'h000 : (k == 1) ? 12'h001 : (k == 2) ? 12'h302 : ins[31:20];
      ins[14:12] = 3'b000;
    end
    return ins;
  endfunction

  // Drive one cycle of stimulus; accepted transactions go to the scoreboard.
  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic ce, input logic st, input logic fl);
    @(negedge d_clk);
    d_i_instr = ins; d_i_pc = pc; d_i_ce = ce; d_i_stall = st; d_i_flush = fl;
    if (ce && !st && !fl) q.push_back(model(ins, pc));
    #1;
    check("rs1_p", 32'(d_o_addr_rs1_p), 32'(ins[19:15]));
    check("rs2_p", 32'(d_o_addr_rs2_p), 32'(ins[24:20]));
    check("rd_p",  32'(d_o_addr_rd_p),  32'(ins[11:7]));
    check("stall_out", 32'(d_o_stall), 32'(st));
    check("flush_out", 32'(d_o_flush), 32'(fl));
  endtask

  // Monitor: per edge, pop the scoreboard on acceptance, else expect the previous state held.
  initial begin
    exp_t last;
    bit exp_ce, acc, fl, st;
    last = zero_exp();
    exp_ce = 1'b0;
    forever begin
      @(posedge d_clk);
      if (!d_rst) begin
        last = zero_exp();
        exp_ce = 1'b0;
      end else begin
        acc = d_i_ce & ~d_i_stall & ~d_i_flush;
        fl  = d_i_flush;
        st  = d_i_stall;
        #1;
        if (acc) begin
          exp_ce = 1'b1;
          if (q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
          else last = q.pop_front();
        end else if (fl) begin
          exp_ce = 1'b0;
        end else if (!st) begin
          exp_ce = 1'b0;
        end
        check("o_ce",      32'(d_o_ce), 32'(exp_ce));
        check("o_pc",      d_o_pc, last.pc);
        check("rs1",       32'(d_o_addr_rs1), 32'(last.rs1));
        check("rs2",       32'(d_o_addr_rs2), 32'(last.rs2));
        check("rd",        32'(d_o_addr_rd), 32'(last.rd));
        check("funct3",    32'(d_o_funct3), 32'(last.f3));
        check("alu",       32'(d_o_alu), 32'(last.alu));
        check("opcode",    32'(d_o_opcode), 32'(last.opc));
        check("exception", 32'(d_o_exception), 32'(last.exc));
        if (last.imm_chk) check("imm", d_o_imm, last.imm);
      end
    end
  end

  initial begin
    logic [31:0] dir [0:15];
    logic [31:0] ins;
    dir = '{32'h003100B3, 32'h40628233, 32'h01040393, 32'h00452483,
            32'h00B62423, 32'h00E68263, 32'h020107EF, 32'h01488867,
            32'h12345937, 32'hABCDE997, 32'h0000007F, 32'h00000073,
            32'h00100073, 32'h30200073, 32'h00A00073, 32'h4000D093};
    repeat (2) @(negedge d_clk);
    #1;
    check("rst_ce",  32'(d_o_ce), 32'd0);
    check("rst_pc",  d_o_pc, 32'd0);
    check("rst_imm", d_o_imm, 32'd0);
    check("rst_alu", 32'(d_o_alu), 32'd0);
    check("rst_opc", 32'(d_o_opcode), 32'd0);
    check("rst_exc", 32'(d_o_exception), 32'd0);
    check("rst_rd",  32'(d_o_addr_rd), 32'd0);
    @(negedge d_clk);
    d_rst = 1'b1;

    for (int i = 0; i < 16; i++) drive(dir[i], 32'(4 * (i + 1)), 1'b1, 1'b0, 1'b0);
    drive(32'h003100B3, 32'h100, 1'b1, 1'b1, 1'b0);
    drive(32'h40628233, 32'h104, 1'b1, 1'b1, 1'b0);
    drive(32'h01040393, 32'h108, 1'b1, 1'b0, 1'b0);
    drive(32'h00452483, 32'h10C, 1'b1, 1'b0, 1'b1);
    drive(32'h00B62423, 32'h110, 1'b1, 1'b0, 1'b0);
    drive(32'h00E68263, 32'h114, 1'b1, 1'b1, 1'b1);
    drive(32'h020107EF, 32'h118, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      ins = gen_instr();
      drive(ins, $urandom, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 9) == 0));
    end

    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge d_clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_decoder.md
Name: rv32_decoder

Overview:
- RV32I instruction-decode pipeline stage, between fetch and execute.
- Splits each fetched instruction into register addresses, a sign-extended immediate, funct3, a one-hot ALU operation, a one-hot opcode class and exception flags.
- Registers all of these with the PC and forwards pipeline control (ce/stall/flush).
- Also emits unregistered source/destination addresses so the register file can be read in the same cycle.

Parameters:
- DWIDTH, 32, immediate/data width
- IWIDTH, 32, instruction width
- AWIDTH, 5, register address width
- PC_WIDTH, 32, program counter width

Ports:
- d_clk  in  1  clock, rising edge
- d_rst  in  1  reset, asynchronous, active-low
- d_i_instr  in  IWIDTH  fetched instruction
- d_i_pc  in  PC_WIDTH  PC of d_i_instr
- d_i_ce  in  1  input valid / clock enable from fetch
- d_i_stall  in  1  stall request from downstream
- d_i_flush  in  1  flush request from downstream
- d_o_pc  out  PC_WIDTH  registered PC
- d_o_addr_rs1 / d_o_addr_rs2 / d_o_addr_rd  out  AWIDTH  registered instr[19:15] / [24:20] / [11:7]
- d_o_addr_rs1_p / d_o_addr_rs2_p / d_o_addr_rd_p  out  AWIDTH  combinational versions of the same fields, taken from d_i_instr
- d_o_imm  out  DWIDTH  registered sign-extended immediate
- d_o_funct3  out  3  registered instr[14:12]
- d_o_alu  out  ALU_WIDTH (14)  one-hot, bits 0..13 = ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, EQ, NEQ, GE, GEU
- d_o_opcode  out  OPCODE_WIDTH (11)  one-hot, bits 0..10 = RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE
- d_o_exception  out  EXCEPTION_WIDTH (4)  bits 0..3 = ILLEGAL, ECALL, EBREAK, MRET
- d_o_ce  out  1  registered valid to execute
- d_o_stall  out  1  stall to fetch
- d_o_flush  out  1  flush to fetch

Behaviour:
- Reset: d_rst=0 asynchronously clears every registered output to 0, including d_o_ce.
- Register update: on a rising edge with d_i_ce=1 and d_o_stall=0, all registered outputs load the decode of d_i_instr/d_i_pc. Latency is 1 cycle.
- d_o_ce: loads d_i_ce when not stalled.
- Stall: d_o_stall = d_i_stall, combinational. While stalled, all registered outputs hold, including d_o_ce.
- Flush: d_o_flush = d_i_flush, combinational. At an edge with d_i_flush=1, d_o_ce <= 0 regardless of stall; data registers may hold. Flush has priority over stall and ce.
- Opcode classes (instr[6:0]): 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, 1110011 SYSTEM, 0001111 FENCE.
- Any other opcode: ILLEGAL=1 and d_o_opcode=0.
- Immediates (sign bit is instr[31]):
  - I/LOAD/JALR: sext(instr[31:20]).
  - STORE: sext({[31:25],[11:7]}).
  - BRANCH: sext({[31],[7],[30:25],[11:8],0}).
  - JAL: sext({[31],[19:12],[20],[30:21],0}).
  - LUI/AUIPC: {instr[31:12],12'b0}.
  - R/SYSTEM/FENCE: imm = sext(instr[31:20]) (used for CSR/system decode).
- ALU selection:
  - R-type: funct3 000 gives ADD, or SUB when instr[30]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when instr[30]=1; 110 OR; 111 AND.
  - I-type: same mapping, except 000 is always ADD; 101 uses instr[30] for SRAI.
  - BRANCH: funct3 000 EQ, 001 NEQ, 100 SLT, 101 GE, 110 SLTU, 111 GEU; 010/011 are ILLEGAL.
  - LOAD, STORE, JAL, JALR, LUI, AUIPC: ADD.
  - SYSTEM, FENCE, illegal: d_o_alu = 0.
- Illegal conditions:
  - R-type with funct7 not 0000000 or 0100000.
  - 0100000 with funct3 other than 000/101.
  - I-type shift with an invalid funct7.
  - JALR funct3 ≠ 000.
- SYSTEM with funct3=000: imm 0x000 → ECALL, 0x001 → EBREAK, 0x302 → MRET, any other value → ILLEGAL.
- Exception bits are registered like the other outputs and are mutually exclusive.

Test Plan:
- Reset: hold d_rst=0 for 2 cycles → all outputs 0; release, then d_i_ce=1.
- add x1,x2,x3 (0x003100B3), pc=4 → rs1=2 rs2=3 rd=1, alu=ADD, opcode=RTYPE, d_o_pc=4, d_o_ce=1. Then sub x4,x5,x6 (0x40628233) → rs1=5 rs2=6 rd=4, alu=SUB.
- addi x7,x8,16 → rs1=8 rd=7 imm=16, ITYPE. lw x9,4(x10) → rs1=10 rd=9 imm=4, LOAD. sw x11,8(x12) → rs1=12 rs2=11 imm=8, STORE.
- beq x13,x14 with imm[4:1]=0010 → rs1=13 rs2=14 imm=4, alu=EQ, BRANCH. jal x15 with imm[19:12]=16 and imm[10:1]=16 → rd=15 imm=65568.
- jalr x16,x17,20 → rs1=17 rd=16 imm=20. lui x18,0x12345 → imm=0x12345000. auipc x19,0xABCDE → imm=0xABCDE000.
- Control checks:
  - stall=1 → outputs hold, d_o_stall=1.
  - flush=1 → d_o_ce=0 next edge.
  - opcode 0x7F → ILLEGAL=1.
  - ecall 0x00000073 → ECALL=1.
  - _p addresses follow d_i_instr with no clock edge.
